sprite_rom_arbiter: RTL

Shares one single-port sprite/background block ROM among up to `N_REQ` pixel requesters (background, Mario, Kong, barrels). It sits between the per-object display units and the ROM, ahead of the `vga_data` colour mux. Each cycle it grants at most one requester, forwards that requester's address to the ROM, and returns the ROM word to the same requester with a one-hot valid. Issue is fully pipelined: one read per cycle, with a fixed latency.

---
 rtl/sprite_rom_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one single-port sprite/background ROM among N_REQ pixel
//   requesters (background, Mario, Kong, barrels). One read may be issued
//   per cycle; each returned word comes back to its requester with a
//   one-hot valid, ROM_LAT+2 cycles after the grant, in grant order.
//
//   Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest
//   index wins, no priority pointer). Undefined: round-robin.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   req       per-requester read request (level)
//   addr      flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       one-hot grant, combinational from req and the pointer
//   rom_en    registered ROM read enable
//   rom_addr  registered ROM address
//   rom_data  ROM read data, valid ROM_LAT cycles after rom_addr
//   rd_valid  registered one-hot return strobe
//   rd_data   registered returned word, shared by all requesters
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  ptr;
  logic              win_any;
  logic [PTR_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [N_REQ-1:0]  tag_p [ROM_LAT+1];

  // Arbitration: search starts at ptr and wraps; reset masks all grants so
  // nothing is issued in a cycle where the pipeline is being cleared.
  always_comb begin
    gnt      = '0;
    win_any  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_any && req[(int'(ptr) + k) % N_REQ]) begin
          win_any = 1'b1;
          win_idx = PTR_W'((int'(ptr) + k) % N_REQ);
        end
      end
    end
    if (win_any) begin
      gnt[win_idx] = 1'b1;
      win_addr     = addr[int'(win_idx)*ADDR_W +: ADDR_W];
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // The winner drops to lowest priority for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (int'(win_idx) == N_REQ-1) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // Issue stage: address to the ROM one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= win_any;
      if (win_any) begin
        rom_addr <= win_addr;
      end
    end
  end

  // Tag pipeline: tag_p[ROM_LAT] lines up with rom_data for the same read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= ROM_LAT; s++) begin
        tag_p[s] <= '0;
      end
    end else begin
      tag_p[0] <= gnt;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

  // Return stage: capture the ROM word only for a live tag, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= tag_p[ROM_LAT];
      if (|tag_p[ROM_LAT]) begin
        rd_data <= rom_data;
      end
    end
  end

endmodule
